// File: rtl/shift_pkg.sv
// Shared types for the multi-cycle shift unit.
//   shift_op_t    : shift/rotate function select
//   shift_state_t : sequencing states of seq_shifter
package shift_pkg;

    typedef enum logic [1:0] {
        SHL_FN = 2'b00,
        SHR_FN = 2'b01,
        ROL_FN = 2'b10,
        ROR_FN = 2'b11
    } shift_op_t;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        SHIFT = 2'b01,
        DONE  = 2'b10
    } shift_state_t;

endpackage

// File: rtl/shift_step.sv
// Single-bit shift/rotate step, purely combinational.
// Ports:
//   w_i     : current working value
//   op_i    : function select
//   w_o     : value after one step
//   carry_o : bit moved out of the word by this step
module shift_step
    import shift_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] w_i,
    input  shift_op_t        op_i,
    output logic [WIDTH-1:0] w_o,
    output logic             carry_o
);

    always_comb begin
        w_o     = w_i;
        carry_o = 1'b0;
        case (op_i)
            SHL_FN: begin
                w_o     = {w_i[WIDTH-2:0], 1'b0};
                carry_o = w_i[WIDTH-1];
            end
            SHR_FN: begin
                w_o     = {1'b0, w_i[WIDTH-1:1]};
                carry_o = w_i[0];
            end
            ROL_FN: begin
                w_o     = {w_i[WIDTH-2:0], w_i[WIDTH-1]};
                carry_o = w_i[WIDTH-1];
            end
            ROR_FN: begin
                w_o     = {w_i[0], w_i[WIDTH-1:1]};
                carry_o = w_i[0];
            end
            default: begin
                w_o     = w_i;
                carry_o = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/seq_shifter.sv
// Multi-cycle shifter/rotator: one bit position per clock, start/done handshake.
//
//   state | meaning
//   ------+-----------------------------------------------------------
//   IDLE  | waiting for start; the only state in which start is accepted
//   SHIFT | one step per clock, down-counter holds remaining steps
//   DONE  | one cycle; result and flags valid, done asserted
//
// Ports:
//   clk, rst_n   : clock, asynchronous active-low reset
//   start        : request (accepted in IDLE only)
//   data         : operand, sampled on the accepting edge
//   opcode       : SHL/SHR/ROL/ROR
//   shift_count  : number of single-bit steps, sampled on the accepting edge
//   c_in         : carry reported for a zero-step request
//   busy         : high from the accepting edge until back in IDLE
//   done         : one-cycle pulse, result valid
//   shift_out    : registered result
//   Z, C         : zero flag, last bit moved out
module seq_shifter
    import shift_pkg::*;
#(
    parameter int WIDTH   = 8,
    parameter int COUNT_W = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic [WIDTH-1:0]   data,
    input  shift_op_t          opcode,
    input  logic [COUNT_W-1:0] shift_count,
    input  logic               c_in,
    output logic               busy,
    output logic               done,
    output logic [WIDTH-1:0]   shift_out,
    output logic               Z,
    output logic               C
);

    shift_state_t       state_q, state_d;
    logic [WIDTH-1:0]   w_q, w_d;
    shift_op_t          op_q, op_d;
    logic [COUNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0]   shift_out_q, shift_out_d;
    logic               z_q, z_d;
    logic               c_q, c_d;

    logic [WIDTH-1:0]   step_w;
    logic               step_c;
    logic               last_step;
    logic               accept;

    shift_step #(
        .WIDTH(WIDTH)
    ) u_step (
        .w_i     (w_q),
        .op_i    (op_q),
        .w_o     (step_w),
        .carry_o (step_c)
    );

    assign accept    = (state_q == IDLE) && start;
    assign last_step = (state_q == SHIFT) && (cnt_q == COUNT_W'(1));

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = (shift_count == '0) ? DONE : SHIFT;
                end
            end
            SHIFT: begin
                if (cnt_q == COUNT_W'(1)) begin
                    state_d = DONE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Output decode (all from registered state)
    always_comb begin
        busy = (state_q != IDLE);
        done = (state_q == DONE);
    end

    // Datapath: working register, down-counter, result registers.
    // Result registers load only on entry to DONE, so they hold the last
    // result through IDLE and the next operation.
    always_comb begin
        w_d         = w_q;
        op_d        = op_q;
        cnt_d       = cnt_q;
        shift_out_d = shift_out_q;
        z_d         = z_q;
        c_d         = c_q;
        if (accept) begin
            w_d   = data;
            op_d  = opcode;
            cnt_d = shift_count;
            if (shift_count == '0) begin
                shift_out_d = data;
                z_d         = (data == '0);
                c_d         = c_in;
            end
        end else if (state_q == SHIFT) begin
            w_d   = step_w;
            cnt_d = cnt_q - COUNT_W'(1);
            if (last_step) begin
                shift_out_d = step_w;
                z_d         = (step_w == '0);
                c_d         = step_c;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            w_q         <= '0;
            op_q        <= SHL_FN;
            cnt_q       <= '0;
            shift_out_q <= '0;
            z_q         <= 1'b0;
            c_q         <= 1'b0;
        end else begin
            w_q         <= w_d;
            op_q        <= op_d;
            cnt_q       <= cnt_d;
            shift_out_q <= shift_out_d;
            z_q         <= z_d;
            c_q         <= c_d;
        end
    end

    assign shift_out = shift_out_q;
    assign Z         = z_q;
    assign C         = c_q;

endmodule

// File: tb/tb_seq_shifter.sv
module tb_seq_shifter;
    import shift_pkg::*;

    localparam int WIDTH   = 8;
    localparam int COUNT_W = 4;
    localparam int MAX_LAT = 40;

    logic               clk;
    logic               rst_n;
    logic               start;
    logic [WIDTH-1:0]   data;
    shift_op_t          opcode;
    logic [COUNT_W-1:0] shift_count;
    logic               c_in;
    logic               busy;
    logic               done;
    logic [WIDTH-1:0]   shift_out;
    logic               Z;
    logic               C;

    int checks;
    int errors;

    seq_shifter #(
        .WIDTH   (WIDTH),
        .COUNT_W (COUNT_W)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .data        (data),
        .opcode      (opcode),
        .shift_count (shift_count),
        .c_in        (c_in),
        .busy        (busy),
        .done        (done),
        .shift_out   (shift_out),
        .Z           (Z),
        .C           (C)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string              name;
        shift_op_t          op;
        logic [WIDTH-1:0]   din;
        logic [COUNT_W-1:0] cnt;
        logic               cin;
        logic [WIDTH-1:0]   e_out;
        logic               e_c;
        logic               e_z;
    } vec_t;

    vec_t vecs[12];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Called at a negedge; returns at the negedge after the IDLE-return check.
    task automatic run_op(input string name, input shift_op_t op, input logic [WIDTH-1:0] din,
                          input logic [COUNT_W-1:0] cnt, input logic cin,
                          input logic [WIDTH-1:0] e_out, input logic e_c, input logic e_z);
        int  lat;
        bit  busy_ok;
        opcode      = op;
        data        = din;
        shift_count = cnt;
        c_in        = cin;
        start       = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start   = 1'b0;
        lat     = 1;
        busy_ok = 1'b1;
        while (!done && lat < MAX_LAT) begin
            if (!busy) busy_ok = 1'b0;
            @(negedge clk);
            lat++;
        end
        if (!busy) busy_ok = 1'b0;
        check({name, " done"}, done, 1);
        check({name, " latency"}, lat, int'(cnt) + 1);
        check({name, " busy span"}, busy_ok, 1);
        check({name, " shift_out"}, shift_out, e_out);
        check({name, " C"}, C, e_c);
        check({name, " Z"}, Z, e_z);
        @(negedge clk);
        check({name, " done pulse end"}, done, 0);
        check({name, " busy end"}, busy, 0);
        check({name, " hold shift_out"}, shift_out, e_out);
    endtask

    initial begin
        int  lat;
        bit  seen;
        checks      = 0;
        errors      = 0;
        rst_n       = 1'b0;
        start       = 1'b0;
        data        = '0;
        opcode      = SHL_FN;
        shift_count = '0;
        c_in        = 1'b0;

        vecs[0]  = '{"shl_b5_3",  SHL_FN, 8'hB5, 4'd3,  1'b0, 8'hA8, 1'b1, 1'b0};
        vecs[1]  = '{"shr_01_1",  SHR_FN, 8'h01, 4'd1,  1'b0, 8'h00, 1'b1, 1'b1};
        vecs[2]  = '{"rol_81_1",  ROL_FN, 8'h81, 4'd1,  1'b0, 8'h03, 1'b1, 1'b0};
        vecs[3]  = '{"ror_81_4",  ROR_FN, 8'h81, 4'd4,  1'b0, 8'h18, 1'b0, 1'b0};
        vecs[4]  = '{"cnt0_cin1", SHL_FN, 8'h5A, 4'd0,  1'b1, 8'h5A, 1'b1, 1'b0};
        vecs[5]  = '{"shl_ff_9",  SHL_FN, 8'hFF, 4'd9,  1'b0, 8'h00, 1'b0, 1'b1};
        vecs[6]  = '{"rol_3c_8",  ROL_FN, 8'h3C, 4'd8,  1'b1, 8'h3C, 1'b0, 1'b0};
        vecs[7]  = '{"shr_80_15", SHR_FN, 8'h80, 4'd15, 1'b1, 8'h00, 1'b0, 1'b1};
        vecs[8]  = '{"ror_01_1",  ROR_FN, 8'h01, 4'd1,  1'b0, 8'h80, 1'b1, 1'b0};
        vecs[9]  = '{"cnt0_zero", ROR_FN, 8'h00, 4'd0,  1'b0, 8'h00, 1'b0, 1'b1};
        vecs[10] = '{"shl_01_8",  SHL_FN, 8'h01, 4'd8,  1'b0, 8'h00, 1'b1, 1'b1};
        vecs[11] = '{"shr_80_8",  SHR_FN, 8'h80, 4'd8,  1'b0, 8'h00, 1'b1, 1'b1};

        repeat (3) @(negedge clk);
        check("reset busy", busy, 0);
        check("reset done", done, 0);
        check("reset shift_out", shift_out, 0);
        check("reset Z", Z, 0);
        check("reset C", C, 0);
        rst_n = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 12; i++) begin
            run_op(vecs[i].name, vecs[i].op, vecs[i].din, vecs[i].cnt, vecs[i].cin,
                   vecs[i].e_out, vecs[i].e_c, vecs[i].e_z);
        end

        // start held high through SHIFT and DONE with a different request:
        // ignored until IDLE, then accepted.
        opcode = SHL_FN; data = 8'hB5; shift_count = 4'd3; c_in = 1'b0; start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        opcode = ROR_FN; data = 8'h81; shift_count = 4'd4;
        lat = 1;
        while (!done && lat < MAX_LAT) begin
            @(negedge clk);
            lat++;
        end
        check("ign latency", lat, 4);
        check("ign shift_out", shift_out, 8'hA8);
        check("ign C", C, 1);
        @(negedge clk);
        check("ign idle busy", busy, 0);
        check("ign idle shift_out", shift_out, 8'hA8);
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        check("second accepted busy", busy, 1);
        lat = 1;
        while (!done && lat < MAX_LAT) begin
            @(negedge clk);
            lat++;
        end
        check("second latency", lat, 5);
        check("second shift_out", shift_out, 8'h18);
        check("second C", C, 0);
        @(negedge clk);

        // Reset mid-shift after 4 steps.
        opcode = SHL_FN; data = 8'hB5; shift_count = 4'd10; start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        check("midrst busy before", busy, 1);
        rst_n = 1'b0;
        #1;
        check("midrst busy", busy, 0);
        check("midrst done", done, 0);
        check("midrst shift_out", shift_out, 0);
        check("midrst Z", Z, 0);
        check("midrst C", C, 0);
        seen = 1'b0;
        repeat (2) begin
            @(negedge clk);
            if (done || busy) seen = 1'b1;
        end
        rst_n = 1'b1;
        repeat (12) begin
            @(negedge clk);
            if (done || busy) seen = 1'b1;
        end
        check("midrst no done after release", seen, 0);
        run_op("after_rst_rol", ROL_FN, 8'h81, 4'd1, 1'b0, 8'h03, 1'b1, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
